// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings used by the execute-stage ALU and the
// state encoding of the multiply sequencer that drives it.
package alu_pkg;

   localparam logic [2:0] ALU_OP_ADD = 3'h0;
   localparam logic [2:0] ALU_OP_NOP = 3'h1;
   localparam logic [2:0] ALU_OP_SLL = 3'h5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply sequencer. Computes the low WIDTH bits of op_a*op_b
// by borrowing the shared ALU for adds and left shifts, one step per cycle.
// Optional build macro MUL_EARLY_EXIT_EN: finish as soon as no multiplier
// bits remain instead of always walking all WIDTH bit positions.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] product,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result
);

   localparam int IDX_W = $clog2(WIDTH);

   mul_state_e       state, state_nxt;
   logic [WIDTH-1:0] mcand, mcand_nxt;
   logic [WIDTH-1:0] mplier, mplier_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [IDX_W-1:0] idx, idx_nxt;

   // Handshake and result come straight from registered state only.
   assign start_ready = (state == IDLE);
   assign done_valid  = (state == DONE);
   assign product     = acc;

   // State and datapath registers; reset drops any in-flight multiply.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         idx    <= '0;
      end else begin
         state  <= state_nxt;
         mcand  <= mcand_nxt;
         mplier <= mplier_nxt;
         acc    <= acc_nxt;
         idx    <= idx_nxt;
      end
   end

   // Next-state, datapath updates and ALU steering for each sequencer step.
   always_comb begin
      state_nxt  = state;
      mcand_nxt  = mcand;
      mplier_nxt = mplier;
      acc_nxt    = acc;
      idx_nxt    = idx;
      alu_op     = ALU_OP_NOP;
      alu_a      = '0;
      alu_b      = '0;

      case (state)
         IDLE: begin
            if (start_valid) begin
               mcand_nxt  = op_a;
               mplier_nxt = op_b;
               acc_nxt    = '0;
               idx_nxt    = '0;
               state_nxt  = op_b[0] ? ADD : SHIFT;
`ifdef MUL_EARLY_EXIT_EN
               if (op_b == '0) state_nxt = DONE;
`endif
            end
         end

         ADD: begin
            alu_op    = ALU_OP_ADD;
            alu_a     = acc;
            alu_b     = mcand;
            acc_nxt   = alu_result;
            state_nxt = SHIFT;
         end

         SHIFT: begin
            alu_op     = ALU_OP_SLL;
            alu_a      = mcand;
            mcand_nxt  = alu_result;
            mplier_nxt = mplier >> 1;
            idx_nxt    = idx + IDX_W'(1);
            // mplier[1] is the bit that becomes the LSB after this shift.
            if (idx == IDX_W'(WIDTH - 1)) state_nxt = DONE;
            else                          state_nxt = mplier[1] ? ADD : SHIFT;
`ifdef MUL_EARLY_EXIT_EN
            if (mplier_nxt == '0) state_nxt = DONE;
`endif
         end

         DONE: begin
            if (done_ready) state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural ALU attached to the
// alu_* ports. Expected products and latencies go through a scoreboard queue.
module tb_alu_mul_seq;

   localparam int WIDTH = 32;

   typedef struct {
      logic [WIDTH-1:0] prod;
      int               lat;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             done_valid;
   logic             done_ready;
   logic [WIDTH-1:0] product;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic [WIDTH-1:0] alu_result;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   add_cnt = 0;

   alu_mul_seq #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .product     (product),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_result  (alu_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: only the functions the sequencer uses.
   always_comb begin
      alu_result = '0;
      case (alu_op)
         3'h0:    alu_result = alu_a + alu_b;
         3'h5:    alu_result = alu_a << 1;
         default: alu_result = '0;
      endcase
   end

   // Counts cycles in which the ALU was asked to add.
   always @(posedge clk) begin
      if (alu_op == 3'h0) add_cnt <= add_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] exp_prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [63:0] full;
      full = 64'(a) * 64'(b);
      return full[WIDTH-1:0];
   endfunction

   // Edges from the accepting edge to the edge that raises done_valid.
   function automatic int exp_lat(input logic [WIDTH-1:0] b);
      int pc  = 0;
      int msb = -1;
      for (int i = 0; i < WIDTH; i++) begin
         if (b[i]) begin
            pc++;
            msb = i;
         end
      end
`ifdef MUL_EARLY_EXIT_EN
      // op_b == 0 enters DONE on the accepting edge itself.
      return (b == '0) ? 0 : msb + 1 + pc;
`else
      return WIDTH + pc;
`endif
   endfunction

   task automatic push_exp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      exp_t e;
      e.prod = exp_prod(a, b);
      e.lat  = exp_lat(b);
      sb.push_back(e);
   endtask

   task automatic issue(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int n = 0;
      while (!start_ready && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_rdy_wait"}, 64'(start_ready), 64'd1);
      push_exp(a, b);
      op_a        = a;
      op_b        = b;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      check({tag, "_busy"}, 64'(start_ready), 64'd0);
   endtask

   task automatic wait_done(input string tag);
      int   n = 0;
      exp_t e;
      while (!done_valid && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_dv"}, 64'(done_valid), 64'd1);
      check({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, "_lat"}, 64'(n), 64'(e.lat));
         check({tag, "_prod"}, 64'(product), 64'(e.prod));
      end
   endtask

   initial begin
      int seen;
      int add_before;

      rst_n       = 1'b0;
      start_valid = 1'b0;
      done_ready  = 1'b1;
      op_a        = '0;
      op_b        = '0;
      tick();
      tick();
      check("rst_start_ready", 64'(start_ready), 64'd1);
      check("rst_done_valid", 64'(done_valid), 64'd0);
      check("rst_product", 64'(product), 64'd0);
      check("rst_alu_op", 64'(alu_op), 64'd1);
      check("rst_alu_a", 64'(alu_a), 64'd0);
      check("rst_alu_b", 64'(alu_b), 64'd0);
      rst_n = 1'b1;
      tick();

      // 3 x 5 with done_ready held high.
      issue("m3x5", 32'd3, 32'd5);
      wait_done("m3x5");
      tick();
      check("m3x5_idle", 64'(start_ready), 64'd1);

      // Zero multiplier must never request an add.
      add_before = add_cnt;
      issue("bzero", 32'h1234, 32'd0);
      wait_done("bzero");
      check("bzero_no_add", 64'(add_cnt - add_before), 64'd0);
      tick();

      // All-ones and wrapping operands.
      issue("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("ones");
      tick();
      issue("wrap", 32'h0001_0000, 32'h0001_0000);
      wait_done("wrap");
      tick();
      issue("rand", 32'h1234_5678, 32'h9ABC_DEF1);
      wait_done("rand");
      tick();

      // Back-pressure: product held, no accept while DONE.
      done_ready = 1'b0;
      issue("hold", 32'd9, 32'd11);
      wait_done("hold");
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            op_a        = 32'd2;
            op_b        = 32'd2;
            start_valid = 1'b1;
         end
         if (i == 5) start_valid = 1'b0;
         tick();
         check("hold_prod", 64'(product), 64'd99);
         check("hold_dv", 64'(done_valid), 64'd1);
         check("hold_sr", 64'(start_ready), 64'd0);
      end
      done_ready = 1'b1;
      tick();
      check("hold_rel_sr", 64'(start_ready), 64'd1);
      check("hold_rel_dv", 64'(done_valid), 64'd0);
      tick();
      check("hold_no_queue", 64'(start_ready), 64'd1);

      // Reset in the middle of a multiply drops it.
      op_a        = 32'd3;
      op_b        = 32'd5;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
      repeat (10) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_sr", 64'(start_ready), 64'd1);
      check("mid_rst_dv", 64'(done_valid), 64'd0);
      check("mid_rst_op", 64'(alu_op), 64'd1);
      check("mid_rst_prod", 64'(product), 64'd0);
      seen = 0;
      repeat (70) begin
         tick();
         if (done_valid) seen++;
      end
      check("mid_rst_no_done", 64'(seen), 64'd0);
      issue("m7x6", 32'd7, 32'd6);
      wait_done("m7x6");
      tick();

      // Back-to-back with start_valid held high throughout.
      push_exp(32'd2, 32'd3);
      op_a        = 32'd2;
      op_b        = 32'd3;
      start_valid = 1'b1;
      tick();
      check("b2b1_busy", 64'(start_ready), 64'd0);
      push_exp(32'd4, 32'd5);
      op_a = 32'd4;
      op_b = 32'd5;
      wait_done("b2b1");
      tick();
      check("b2b_gap_sr", 64'(start_ready), 64'd1);
      tick();
      check("b2b2_busy", 64'(start_ready), 64'd0);
      start_valid = 1'b0;
      wait_done("b2b2");
      tick();
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
